// File: rtl/issue_pkg.sv
// Decoded-instruction packet layout and field helpers shared by the scheduler and its buffer.
package issue_pkg;

  localparam int ISS_DEPTH = 8;
  localparam int ISS_PKT_W = 86;
  localparam int REG_AW    = 5;

  // Bit 85 is spare.
  localparam int PC_LSB      = 0;
  localparam int INST_LSB    = 32;
  localparam int RD_LSB      = 64;
  localparam int RD_WEN_BIT  = 69;
  localparam int RS1_LSB     = 70;
  localparam int RS1_REN_BIT = 75;
  localparam int RS2_LSB     = 76;
  localparam int RS2_REN_BIT = 81;
  localparam int IS_MEM_BIT  = 82;
  localparam int IS_LOAD_BIT = 83;
  localparam int IS_BR_BIT   = 84;

  typedef logic [ISS_PKT_W-1:0] pkt_t;
  typedef logic [REG_AW-1:0]    reg_addr_t;

  function automatic logic [31:0] pkt_pc(input pkt_t p);
    return p[PC_LSB +: 32];
  endfunction

  function automatic logic [31:0] pkt_inst(input pkt_t p);
    return p[INST_LSB +: 32];
  endfunction

  function automatic reg_addr_t pkt_rd(input pkt_t p);
    return p[RD_LSB +: REG_AW];
  endfunction

  function automatic logic pkt_rd_wen(input pkt_t p);
    return p[RD_WEN_BIT];
  endfunction

  function automatic reg_addr_t pkt_rs1(input pkt_t p);
    return p[RS1_LSB +: REG_AW];
  endfunction

  function automatic logic pkt_rs1_ren(input pkt_t p);
    return p[RS1_REN_BIT];
  endfunction

  function automatic reg_addr_t pkt_rs2(input pkt_t p);
    return p[RS2_LSB +: REG_AW];
  endfunction

  function automatic logic pkt_rs2_ren(input pkt_t p);
    return p[RS2_REN_BIT];
  endfunction

  function automatic logic pkt_is_mem(input pkt_t p);
    return p[IS_MEM_BIT];
  endfunction

  function automatic logic pkt_is_load(input pkt_t p);
    return p[IS_LOAD_BIT];
  endfunction

  function automatic logic pkt_is_br(input pkt_t p);
    return p[IS_BR_BIT];
  endfunction

  // x0 is hardwired, so a source or destination of x0 never forms a dependency.
  function automatic logic pkt_reads(input pkt_t p, input reg_addr_t a);
    return (a != '0) &&
           ((pkt_rs1_ren(p) && (pkt_rs1(p) == a)) ||
            (pkt_rs2_ren(p) && (pkt_rs2(p) == a)));
  endfunction

  function automatic logic pkt_writes(input pkt_t p);
    return pkt_rd_wen(p) && (pkt_rd(p) != '0);
  endfunction

endpackage

// File: rtl/iss_buffer.sv
// 2-in/2-out circular instruction buffer; exposes head and head+1 combinationally.
module iss_buffer
  import issue_pkg::*;
#(
  parameter int DEPTH = ISS_DEPTH,
  parameter int PKT_W = ISS_PKT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               enq_cnt,
  input  logic [1:0]               deq_cnt,
  input  logic [PKT_W-1:0]         wr_pkt0,
  input  logic [PKT_W-1:0]         wr_pkt1,
  output logic [PKT_W-1:0]         head_pkt0,
  output logic [PKT_W-1:0]         head_pkt1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_cnt != 2'd0) mem_d[wr_ptr_q] = wr_pkt0;
      if (enq_cnt == 2'd2) mem_d[wr_ptr_q + PW'(1)] = wr_pkt1;
      // Pointers are exactly PW bits wide, so the adds wrap mod DEPTH.
      wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
      rd_ptr_d = rd_ptr_q + PW'(deq_cnt);
      count_d  = count_q + CW'(enq_cnt) - CW'(deq_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head_pkt0 = mem_q[rd_ptr_q];
  assign head_pkt1 = mem_q[rd_ptr_q + PW'(1)];
  assign count     = count_q;

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue pairing scheduler: buffers decode output, issues 0/1/2 per cycle,
// resolving load-use hazards by splitting pairs or inserting a single bubble.
module dual_issue_scheduler
  import issue_pkg::*;
#(
  parameter int DEPTH         = ISS_DEPTH,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int PKT_W         = ISS_PKT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dec_valid,
  input  logic [PKT_W-1:0] dec_pkt0,
  input  logic [PKT_W-1:0] dec_pkt1,
  output logic             dec_ready,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             iss0_valid,
  output logic [PKT_W-1:0] iss0_pkt,
  output logic             iss1_valid,
  output logic [PKT_W-1:0] iss1_pkt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    buf_count;
  logic [PKT_W-1:0] head0, head1;
  logic [1:0]       enq_cnt, deq_cnt;

  logic                     iss0_valid_q, iss0_valid_d;
  logic                     iss1_valid_q, iss1_valid_d;
  logic [PKT_W-1:0]         iss0_pkt_q, iss0_pkt_d;
  logic [PKT_W-1:0]         iss1_pkt_q, iss1_pkt_d;
  logic                     ld_pend_v_q, ld_pend_v_d;
  logic [RF_ADDR_WIDTH-1:0] ld_pend_rd_q, ld_pend_rd_d;

  logic h_vld, h1_vld, bubble, pair_ok, issue0, issue1;

  iss_buffer #(.DEPTH(DEPTH), .PKT_W(PKT_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_cnt   (enq_cnt),
    .deq_cnt   (deq_cnt),
    .wr_pkt0   (dec_pkt0),
    .wr_pkt1   (dec_pkt1),
    .head_pkt0 (head0),
    .head_pkt1 (head1),
    .count     (buf_count)
  );

  assign dec_ready = !rst && (buf_count <= CW'(DEPTH - 2));

  always_comb begin
    enq_cnt = 2'd0;
    if (dec_ready && !flush && dec_valid[0]) enq_cnt = dec_valid[1] ? 2'd2 : 2'd1;
  end

  always_comb begin
    h_vld   = buf_count >= CW'(1);
    h1_vld  = buf_count >= CW'(2);
    bubble  = h_vld && ld_pend_v_q && pkt_reads(head0, REG_AW'(ld_pend_rd_q));
    // Slot0 result forwarding covers ALU RAW into slot1, so only load results split a pair.
    pair_ok = h1_vld
           && !pkt_is_mem(head1)
           && !pkt_is_br(head0)
           && !(pkt_is_load(head0) && (pkt_rd(head0) != '0) && pkt_reads(head1, pkt_rd(head0)))
           && !(pkt_writes(head0) && pkt_writes(head1) && (pkt_rd(head0) == pkt_rd(head1)))
           && !(ld_pend_v_q && pkt_reads(head1, REG_AW'(ld_pend_rd_q)));
    issue0  = h_vld && !bubble;
    issue1  = issue0 && pair_ok;
    deq_cnt = 2'd0;
    if (!flush && !ex_stall) deq_cnt = {1'b0, issue0} + {1'b0, issue1};
  end

  always_comb begin
    iss0_valid_d = iss0_valid_q;
    iss1_valid_d = iss1_valid_q;
    iss0_pkt_d   = iss0_pkt_q;
    iss1_pkt_d   = iss1_pkt_q;
    ld_pend_v_d  = ld_pend_v_q;
    ld_pend_rd_d = ld_pend_rd_q;
    if (flush) begin
      iss0_valid_d = 1'b0;
      iss1_valid_d = 1'b0;
      ld_pend_v_d  = 1'b0;
    end else if (!ex_stall) begin
      iss0_valid_d = issue0;
      iss1_valid_d = issue1;
      iss0_pkt_d   = head0;
      iss1_pkt_d   = head1;
      // Any non-stalled cycle after a load gives its result time to arrive.
      if (issue0 && pkt_is_load(head0) && (pkt_rd(head0) != '0)) begin
        ld_pend_v_d  = 1'b1;
        ld_pend_rd_d = RF_ADDR_WIDTH'(pkt_rd(head0));
      end else begin
        ld_pend_v_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss0_valid_q <= 1'b0;
      iss1_valid_q <= 1'b0;
      ld_pend_v_q  <= 1'b0;
      ld_pend_rd_q <= '0;
    end else begin
      iss0_valid_q <= iss0_valid_d;
      iss1_valid_q <= iss1_valid_d;
      ld_pend_v_q  <= ld_pend_v_d;
      ld_pend_rd_q <= ld_pend_rd_d;
    end
    iss0_pkt_q <= iss0_pkt_d;
    iss1_pkt_q <= iss1_pkt_d;
  end

  assign iss0_valid = iss0_valid_q;
  assign iss1_valid = iss1_valid_q;
  assign iss0_pkt   = iss0_pkt_q;
  assign iss1_pkt   = iss1_pkt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with hand-computed expectations.
module tb_dual_issue_scheduler;
  import issue_pkg::*;

  localparam int PKT_W = ISS_PKT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       dec_valid;
  logic [PKT_W-1:0] dec_pkt0, dec_pkt1;
  logic             dec_ready;
  logic             ex_stall;
  logic             flush;
  logic             iss0_valid, iss1_valid;
  logic [PKT_W-1:0] iss0_pkt, iss1_pkt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.DEPTH(8), .RF_ADDR_WIDTH(5), .PKT_W(PKT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_pkt0   (dec_pkt0),
    .dec_pkt1   (dec_pkt1),
    .dec_ready  (dec_ready),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .iss0_valid (iss0_valid),
    .iss0_pkt   (iss0_pkt),
    .iss1_valid (iss1_valid),
    .iss1_pkt   (iss1_pkt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input int rd, input logic wen,
                              input int rs1, input logic r1, input int rs2, input logic r2,
                              input logic mem, input logic ld, input logic br);
    pkt_t p = '0;
    p[PC_LSB +: 32]      = pc;
    p[INST_LSB +: 32]    = ~pc;
    p[RD_LSB +: REG_AW]  = REG_AW'(rd);
    p[RD_WEN_BIT]        = wen;
    p[RS1_LSB +: REG_AW] = REG_AW'(rs1);
    p[RS1_REN_BIT]       = r1;
    p[RS2_LSB +: REG_AW] = REG_AW'(rs2);
    p[RS2_REN_BIT]       = r2;
    p[IS_MEM_BIT]        = mem;
    p[IS_LOAD_BIT]       = ld;
    p[IS_BR_BIT]         = br;
    return p;
  endfunction

  function automatic pkt_t alu(input logic [31:0] pc, input int rd, input int rs1, input int rs2);
    return mk(pc, rd, 1'b1, rs1, 1'b1, rs2, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic pkt_t lw(input logic [31:0] pc, input int rd, input int rs1);
    return mk(pc, rd, 1'b1, rs1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic pkt_t sw(input logic [31:0] pc, input int rs1, input int rs2);
    return mk(pc, 0, 1'b0, rs1, 1'b1, rs2, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic pkt_t beq(input logic [31:0] pc, input int rs1, input int rs2);
    return mk(pc, 0, 1'b0, rs1, 1'b1, rs2, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input pkt_t p0, input pkt_t p1);
    dec_valid = v;
    dec_pkt0  = p0;
    dec_pkt1  = p1;
    step();
    dec_valid = 2'b00;
  endtask

  task automatic expect_iss(input string tag, input logic v0, input logic [31:0] pc0,
                            input logic v1, input logic [31:0] pc1);
    check({tag, ".v0"}, 32'(iss0_valid), 32'(v0));
    if (v0) check({tag, ".pc0"}, iss0_pkt[31:0], pc0);
    check({tag, ".v1"}, 32'(iss1_valid), 32'(v1));
    if (v1) check({tag, ".pc1"}, iss1_pkt[31:0], pc1);
  endtask

  initial begin
    rst = 1'b1; dec_valid = 2'b00; dec_pkt0 = '0; dec_pkt1 = '0;
    ex_stall = 1'b0; flush = 1'b0;
    step(); step();
    check("rst.dec_ready", 32'(dec_ready), 32'd0);
    rst = 1'b0;
    step();
    check("rst.count", 32'(dut.buf_count), 32'd0);
    expect_iss("rst", 1'b0, 0, 1'b0, 0);
    check("rst.ready_after", 32'(dec_ready), 32'd1);

    // Independent ALU pair.
    push(2'b11, alu(32'h100, 1, 2, 3), alu(32'h104, 4, 5, 6));
    check("pair.count_in", 32'(dut.buf_count), 32'd2);
    step();
    expect_iss("pair", 1'b1, 32'h100, 1'b1, 32'h104);
    check("pair.count_out", 32'(dut.buf_count), 32'd0);

    // ALU RAW slot0 -> slot1 still pairs.
    push(2'b11, alu(32'h200, 5, 1, 2), alu(32'h204, 6, 5, 3));
    step();
    expect_iss("raw", 1'b1, 32'h200, 1'b1, 32'h204);
    check("raw.rs1", 32'(iss1_pkt[RS1_LSB +: REG_AW]), 32'd5);

    // Load-use: split, then one bubble.
    push(2'b11, lw(32'h300, 5, 10), alu(32'h304, 7, 5, 1));
    step();
    expect_iss("ldu.n1", 1'b1, 32'h300, 1'b0, 0);
    step();
    expect_iss("ldu.n2", 1'b0, 0, 1'b0, 0);
    step();
    expect_iss("ldu.n3", 1'b1, 32'h304, 1'b0, 0);

    // Load to x0 never forms a hazard; WAW on the same rd splits.
    push(2'b11, lw(32'h380, 0, 1), alu(32'h384, 9, 0, 0));
    step();
    expect_iss("x0", 1'b1, 32'h380, 1'b1, 32'h384);
    push(2'b11, alu(32'h390, 9, 1, 2), alu(32'h394, 9, 3, 4));
    step();
    expect_iss("waw.n1", 1'b1, 32'h390, 1'b0, 0);
    step();
    expect_iss("waw.n2", 1'b1, 32'h394, 1'b0, 0);

    // Stores one per cycle; branch at head issues alone.
    push(2'b11, sw(32'h400, 1, 2), sw(32'h404, 3, 4));
    step();
    expect_iss("st.n1", 1'b1, 32'h400, 1'b0, 0);
    step();
    expect_iss("st.n2", 1'b1, 32'h404, 1'b0, 0);
    push(2'b11, beq(32'h408, 1, 2), alu(32'h40c, 8, 1, 2));
    step();
    expect_iss("br.n1", 1'b1, 32'h408, 1'b0, 0);
    step();
    expect_iss("br.n2", 1'b1, 32'h40c, 1'b0, 0);

    // Fill under stall to full, then drain across the pointer wrap.
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(2'b11, alu(32'h500 + 32'(8*i), 10 + 2*i, 0, 0), alu(32'h504 + 32'(8*i), 11 + 2*i, 0, 0));
      check("fill.count", 32'(dut.buf_count), 32'(2*i + 2));
      check("fill.ready", 32'(dec_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    expect_iss("fill.hold", 1'b1, 32'h40c, 1'b0, 0);
    ex_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_iss("drain", 1'b1, 32'h500 + 32'(8*i), 1'b1, 32'h504 + 32'(8*i));
    end
    check("drain.count", 32'(dut.buf_count), 32'd0);

    // count=7 leaves only one free slot, so dec_ready drops.
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) push(2'b11, alu(32'h600, 1, 0, 0), alu(32'h604, 2, 0, 0));
    push(2'b01, alu(32'h608, 3, 0, 0), '0);
    check("c7.count", 32'(dut.buf_count), 32'd7);
    check("c7.ready", 32'(dec_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("c7.flush_count", 32'(dut.buf_count), 32'd0);

    // Flush at count=5 with valid issue registers and incoming pair.
    ex_stall = 1'b0;
    push(2'b11, alu(32'h700, 1, 0, 0), alu(32'h704, 2, 0, 0));
    push(2'b11, alu(32'h708, 3, 0, 0), alu(32'h70c, 4, 0, 0));
    expect_iss("fl.pre", 1'b1, 32'h700, 1'b1, 32'h704);
    ex_stall = 1'b1;
    push(2'b11, alu(32'h710, 5, 0, 0), alu(32'h714, 6, 0, 0));
    push(2'b01, alu(32'h718, 7, 0, 0), '0);
    check("fl.count5", 32'(dut.buf_count), 32'd5);
    flush = 1'b1;
    push(2'b11, alu(32'h720, 8, 0, 0), alu(32'h724, 9, 0, 0));
    flush = 1'b0;
    ex_stall = 1'b0;
    check("fl.count", 32'(dut.buf_count), 32'd0);
    expect_iss("fl", 1'b0, 0, 1'b0, 0);
    check("fl.ready", 32'(dec_ready), 32'd1);
    step();
    expect_iss("fl.after", 1'b0, 0, 1'b0, 0);

    // Reset mid-operation.
    push(2'b11, alu(32'h800, 1, 0, 0), alu(32'h804, 2, 0, 0));
    push(2'b11, alu(32'h808, 3, 0, 0), alu(32'h80c, 4, 0, 0));
    expect_iss("rs.pre", 1'b1, 32'h800, 1'b1, 32'h804);
    rst = 1'b1;
    step();
    check("rs.count", 32'(dut.buf_count), 32'd0);
    expect_iss("rs", 1'b0, 0, 1'b0, 0);
    check("rs.ready_low", 32'(dec_ready), 32'd0);
    rst = 1'b0;
    step();
    check("rs.ready", 32'(dec_ready), 32'd1);
    expect_iss("rs.after", 1'b0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- In-order pairing scheduler between decode and the two execute slots (slot0 = ALU+LSU+branch, slot1 = ALU only).
- Buffers decoded instructions and issues 0, 1 or 2 per cycle.
- Same-cycle ALU RAW from slot0 to slot1 is allowed, because slot0 result forwarding covers it.
- Load-use hazards are resolved by splitting the pair or inserting one bubble, so execute never has to stall for a load.

Parameters:
- DEPTH, 8: instruction buffer entries; power of 2, at least 4.
- RF_ADDR_WIDTH, 5: register address width.
- PKT_W, 86: packed decoded-instruction width; layout is defined in the package.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  2  lane valids; lane1 is valid only when lane0 is valid.
- dec_pkt0  in  PKT_W  lane0 packet, the older instruction.
- dec_pkt1  in  PKT_W  lane1 packet.
- dec_ready  out  1  buffer can accept 2 this cycle.
- ex_stall  in  1  execute hold.
- flush  in  1  redirect; discard all buffered and staged work.
- iss0_valid  out  1  slot0 register valid.
- iss0_pkt  out  PKT_W  slot0 instruction.
- iss1_valid  out  1  slot1 register valid.
- iss1_pkt  out  PKT_W  slot1 instruction.

Behaviour:
Reset (rst=1 at posedge):
- rd_ptr, wr_ptr and count are cleared to 0.
- iss0_valid and iss1_valid are cleared to 0.
- ld_pend_v is cleared to 0.
- dec_ready=0 while rst is high.

Buffer:
- Circular buffer with count of width clog2(DEPTH)+1 and mod-DEPTH pointers that wrap.
- dec_ready = !rst && (DEPTH - count >= 2), from the registered count.
- Enqueue happens only when dec_ready=1; enq = dec_valid[0] + dec_valid[1]. lane0 is written before lane1.
- count_next = count + enq - deq.
- Simultaneous enqueue and dequeue is legal.

Pairing decision (combinational, on head H and H+1):
- H is issuable when count >= 1.
- Bubble condition: ld_pend_v=1 and H reads ld_pend_rd (rs1_ren or rs2_ren with a matching address).
  - Issue nothing.
  - Clear ld_pend_v.
  - deq=0.
- H+1 co-issues only when all of the following hold:
  - count >= 2.
  - H+1 is not mem.
  - H is not a branch.
  - NOT (H is a load with rd≠0, and H+1 reads H.rd).
  - NOT (both write the same rd≠0).
  - NOT (ld_pend_v=1 and H+1 reads ld_pend_rd).
- Otherwise H issues alone in slot0 and slot1 is invalid.
- deq = 0, 1 or 2.

Issue registers (latency):
- An instruction present at head in cycle N appears on iss*_pkt in cycle N+1.
- When ex_stall=1:
  - Issue registers hold.
  - deq=0.
  - ld_pend holds.
  - Enqueue still proceeds.
- When ex_stall=0:
  - Issue registers load the decision.
  - Invalid slots have valid=0; their pkt contents are don't-care.
- Load tracker update: when slot0 is loaded with a load whose rd≠0, set ld_pend_v=1 and ld_pend_rd=rd. Otherwise, when issuing, ld_pend_v=0.

Flush:
- Highest priority over ex_stall and enqueue.
- Next cycle: count=0, pointers equal, both valids 0, ld_pend_v=0.
- dec_pkt on the flush cycle is dropped.

Register x0 never creates a hazard.

Decomposition:
- Package issue_pkg holds:
  - the PKT_W field offsets: pc[31:0], inst[31:0], rd, rd_wen, rs1, rs1_ren, rs2, rs2_ren, is_mem, is_load, is_br;
  - extraction functions for those fields;
  - the DEPTH default.
- Sub-module iss_buffer: 2-in/2-out circular FIFO with count, wr/rd pointers and head/head+1 read ports.
- The top level holds the pairing logic, the load tracker and the issue registers.

Test Plan:
- add x1,x2,x3 ; add x4,x5,x6 enqueued together → next cycle iss0 and iss1 both valid, count 0.
- add x5,x1,x2 ; sub x6,x5,x3 → paired in the same cycle; iss1 rs1=x5 is accepted.
- lw x5 ; add x7,x5,x1 → cycle N+1 iss0=lw alone; N+2 both valids 0 (bubble); N+3 iss0=add.
- sw ; sw ; then beq ; add → stores issue one per cycle in slot0; beq issues alone, then add.
- Enqueue 2/cycle with ex_stall=1 → count climbs to 8; dec_ready drops at count=7; issue registers hold; release gives in-order drain including pointer wrap.
- Buffer count=5 and valid issue registers, assert flush together with dec_valid=2'b11 → next cycle count=0, valids 0, dec_ready=1; reset pulse mid-operation gives the same result.
